// File: rtl/debug_pkg.sv
// Shared constants and types for the debug host: command codes and bytes,
// dump word layout, and the controller state encoding.
package debug_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DUMP_WORDS = 50;

  localparam int unsigned IDX_PC     = 0;
  localparam int unsigned IDX_CYCLES = 1;
  localparam int unsigned IDX_REG0   = 2;
  localparam int unsigned IDX_MEM0   = 34;

  localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [BYTE_W-1:0] BYTE_LOAD = 8'h64;
  localparam logic [BYTE_W-1:0] BYTE_RUN  = 8'h63;
  localparam logic [BYTE_W-1:0] BYTE_STEP = 8'h73;
  localparam logic [BYTE_W-1:0] BYTE_NEXT = 8'h6E;

  typedef enum logic [1:0] {
    CMD_LOAD = 2'd0,
    CMD_RUN  = 2'd1,
    CMD_STEP = 2'd2,
    CMD_NEXT = 2'd3
  } cmd_e;

  typedef enum logic [3:0] {
    IDLE,
    PROG_FETCH,
    PROG_LATCH,
    TX_BYTE,
    TX_WAIT_HI,
    TX_WAIT_LO,
    RX_BYTE,
    DUMP_WRITE,
    FINISH
  } state_e;

  function automatic logic [BYTE_W-1:0] cmd_byte(input cmd_e cmd);
    case (cmd)
      CMD_LOAD: cmd_byte = BYTE_LOAD;
      CMD_RUN:  cmd_byte = BYTE_RUN;
      CMD_STEP: cmd_byte = BYTE_STEP;
      default:  cmd_byte = BYTE_NEXT;
    endcase
  endfunction

endpackage

// File: rtl/debug_word_shifter.sv
// 32-bit word shifter with shared 2-bit byte counter: MSB-first byte
// shift-out for transmit, byte shift-in for receive.
module debug_word_shifter
  import debug_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              shift_out,
  input  logic              shift_in,
  input  logic [BYTE_W-1:0] in_byte,
  output logic [BYTE_W-1:0] msb_byte,
  output logic [1:0]        byte_cnt,
  output logic [WORD_W-1:0] word_in_c
);

  logic [WORD_W-1:0] word;

  assign msb_byte  = word[WORD_W-1 -: BYTE_W];
  assign word_in_c = {word[WORD_W-BYTE_W-1:0], in_byte};

  // Counter wraps 3->0 so a zero count after a shift marks a complete word.
  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      word     <= load_word;
      byte_cnt <= '0;
    end else if (shift_out) begin
      word     <= {word[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
      byte_cnt <= byte_cnt + 2'd1;
    end else if (shift_in) begin
      word     <= word_in_c;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/debug_host.sv
// Debug host controller: streams program ROM to the target over UART and
// collects the 50-word state dump the target returns after RUN/NEXT.
module debug_host
  import debug_pkg::*;
#(
  parameter int unsigned N_REGS     = 32,
  parameter int unsigned N_MEM      = 16,
  parameter int unsigned PROG_DEPTH = 256,
  parameter int unsigned RX_TIMEOUT = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  input  logic [1:0]  i_cmd,
  output logic        o_cmd_ready,
  output logic [7:0]  o_prog_addr,
  input  logic [31:0] i_prog_data,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_busy,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_dump_we,
  output logic [5:0]  o_dump_addr,
  output logic [31:0] o_dump_data,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned AW        = 8;
  localparam int unsigned WCW       = $clog2(DUMP_WORDS);
  localparam int unsigned IDLE_W    = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned DUMP_LAST = IDX_REG0 + N_REGS + N_MEM - 1;
  localparam logic [AW-1:0] PROG_LAST = AW'(PROG_DEPTH - 1);

  state_e            state, state_d;
  cmd_e              cmd_q, cmd_d;
  logic              cmd_phase, cmd_phase_d;
  logic              last_word, last_word_d;
  logic [AW-1:0]     prog_addr_d;
  logic [WCW-1:0]    word_cnt, word_cnt_d;
  logic [IDLE_W-1:0] idle_cnt, idle_cnt_d;
  logic              tx_start_d, dump_we_d, error_d;

  logic              sh_clear, sh_load, sh_shift_out, sh_shift_in;
  logic [WORD_W-1:0] sh_load_word;
  logic [BYTE_W-1:0] sh_msb_byte;
  logic [1:0]        sh_byte_cnt;
  logic [WORD_W-1:0] sh_word_in_c;

  debug_word_shifter u_shifter (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .clear     (sh_clear),
    .load      (sh_load),
    .load_word (sh_load_word),
    .shift_out (sh_shift_out),
    .shift_in  (sh_shift_in),
    .in_byte   (i_rx_data),
    .msb_byte  (sh_msb_byte),
    .byte_cnt  (sh_byte_cnt),
    .word_in_c (sh_word_in_c)
  );

  // Next-state and datapath control.
  always_comb begin
    state_d      = state;
    cmd_d        = cmd_q;
    cmd_phase_d  = cmd_phase;
    last_word_d  = last_word;
    prog_addr_d  = o_prog_addr;
    word_cnt_d   = word_cnt;
    idle_cnt_d   = '0;
    tx_start_d   = 1'b0;
    dump_we_d    = 1'b0;
    error_d      = 1'b0;
    sh_clear     = 1'b0;
    sh_load      = 1'b0;
    sh_load_word = '0;
    sh_shift_out = 1'b0;
    sh_shift_in  = 1'b0;

    case (state)
      IDLE: begin
        if (i_cmd_valid && o_cmd_ready) begin
          cmd_d        = cmd_e'(i_cmd);
          cmd_phase_d  = 1'b1;
          last_word_d  = 1'b0;
          prog_addr_d  = '0;
          word_cnt_d   = WCW'(IDX_PC);
          sh_load      = 1'b1;
          sh_load_word = {cmd_byte(cmd_e'(i_cmd)), 24'h00_0000};
          state_d      = TX_BYTE;
        end
      end

      PROG_FETCH: state_d = PROG_LATCH;

      // The final slot is forced to the halt word so LOAD always terminates.
      PROG_LATCH: begin
        sh_load      = 1'b1;
        sh_load_word = (o_prog_addr == PROG_LAST) ? HALT_WORD : i_prog_data;
        last_word_d  = (sh_load_word == HALT_WORD);
        state_d      = TX_BYTE;
      end

      TX_BYTE: begin
        if (!i_tx_busy) begin
          tx_start_d   = 1'b1;
          sh_shift_out = 1'b1;
          state_d      = TX_WAIT_HI;
        end
      end

      TX_WAIT_HI: begin
        if (i_tx_busy) state_d = TX_WAIT_LO;
      end

      TX_WAIT_LO: begin
        if (!i_tx_busy) begin
          if (cmd_phase) begin
            cmd_phase_d = 1'b0;
            case (cmd_q)
              CMD_LOAD: state_d = PROG_FETCH;
              CMD_STEP: state_d = FINISH;
              default: begin
                sh_clear = 1'b1;
                state_d  = RX_BYTE;
              end
            endcase
          end else if (sh_byte_cnt == 2'd0) begin
            if (last_word) begin
              state_d = FINISH;
            end else begin
              prog_addr_d = o_prog_addr + AW'(1);
              state_d     = PROG_FETCH;
            end
          end else begin
            state_d = TX_BYTE;
          end
        end
      end

      // Idle counter runs only between received bytes; a stall aborts the dump.
      RX_BYTE: begin
        if (i_rx_valid) begin
          sh_shift_in = 1'b1;
          if (sh_byte_cnt == 2'd3) begin
            dump_we_d = 1'b1;
            state_d   = DUMP_WRITE;
          end
        end else if (idle_cnt == IDLE_W'(RX_TIMEOUT - 1)) begin
          error_d  = 1'b1;
          sh_clear = 1'b1;
          state_d  = IDLE;
        end else begin
          idle_cnt_d = idle_cnt + IDLE_W'(1);
        end
      end

      DUMP_WRITE: begin
        if (word_cnt == WCW'(DUMP_LAST)) begin
          state_d = FINISH;
        end else begin
          word_cnt_d = word_cnt + WCW'(1);
          state_d    = RX_BYTE;
        end
      end

      FINISH: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      cmd_q       <= CMD_LOAD;
      cmd_phase   <= 1'b0;
      last_word   <= 1'b0;
      word_cnt    <= '0;
      idle_cnt    <= '0;
      o_cmd_ready <= 1'b0;
      o_prog_addr <= '0;
      o_tx_start  <= 1'b0;
      o_tx_data   <= '0;
      o_dump_we   <= 1'b0;
      o_dump_addr <= '0;
      o_dump_data <= '0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_q       <= cmd_d;
      cmd_phase   <= cmd_phase_d;
      last_word   <= last_word_d;
      word_cnt    <= word_cnt_d;
      idle_cnt    <= idle_cnt_d;
      o_cmd_ready <= (state_d == IDLE);
      o_prog_addr <= prog_addr_d;
      o_tx_start  <= tx_start_d;
      o_dump_we   <= dump_we_d;
      o_done      <= (state_d == FINISH);
      o_error     <= error_d;
      if (tx_start_d) o_tx_data <= sh_msb_byte;
      if (dump_we_d) begin
        o_dump_addr <= 6'(word_cnt);
        o_dump_data <= sh_word_in_c;
      end
    end
  end

endmodule

// File: tb/tb_debug_host.sv
// Scoreboard bench for debug_host: ROM, UART and target models with a
// queue-based monitor checking every transmitted byte, dump write and pulse.
module tb_debug_host;

  localparam int unsigned RX_TO = 100;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic        o_cmd_ready;
  logic [7:0]  o_prog_addr;
  logic [31:0] i_prog_data;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_busy;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_dump_we;
  logic [5:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_done;
  logic        o_error;

  debug_host #(
    .N_REGS(32), .N_MEM(16), .PROG_DEPTH(256), .RX_TIMEOUT(RX_TO)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .o_prog_addr(o_prog_addr), .i_prog_data(i_prog_data),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .i_tx_busy(i_tx_busy),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_dump_we(o_dump_we),
    .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data), .o_done(o_done),
    .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_len = 10;
  int busy_cnt = 0;
  logic [31:0] rom [256];

  logic [7:0]  exp_tx_q [$];
  logic [37:0] exp_dump_q [$];
  logic [7:0]  rx_q [$];
  int exp_done = 0, exp_err = 0;
  int tx_seen = 0, we_seen = 0, done_seen = 0, err_seen = 0;
  int busy_fall_cyc = 0, last_we_cyc = 0, last_rx_cyc = 0, max_addr = 0;
  logic [5:0]  last_we_addr = '0;
  bit done_after_dump = 0;
  logic prev_busy = 1'b0;
  logic [7:0]  mon_b;
  logic [37:0] mon_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // ROM with one cycle of read latency.
  always @(posedge i_clk) i_prog_data <= rom[o_prog_addr];

  // UART transmitter: busy for busy_len cycles starting the cycle after a start.
  always @(posedge i_clk) begin
    if (o_tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign i_tx_busy = (busy_cnt != 0);

  // Monitor: pops expectations whenever the DUT presents an output event.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (prev_busy && !i_tx_busy) busy_fall_cyc = cyc;
      if (int'(o_prog_addr) > max_addr) max_addr = int'(o_prog_addr);
      if (o_tx_start) begin
        tx_seen++;
        check("tx_expected_pending", 32'(exp_tx_q.size() > 0), 1);
        if (exp_tx_q.size() > 0) begin
          mon_b = exp_tx_q.pop_front();
          check("tx_byte", 32'(o_tx_data), 32'(mon_b));
        end
      end
      if (o_dump_we) begin
        we_seen++;
        last_we_cyc  = cyc;
        last_we_addr = o_dump_addr;
        check("dump_expected_pending", 32'(exp_dump_q.size() > 0), 1);
        if (exp_dump_q.size() > 0) begin
          mon_d = exp_dump_q.pop_front();
          check("dump_addr", 32'(o_dump_addr), 32'(mon_d[37:32]));
          check("dump_data", o_dump_data, mon_d[31:0]);
        end
      end
      if (o_done) begin
        done_seen++;
        check("done_expected_pending", 32'(exp_done > 0), 1);
        if (exp_done > 0) exp_done--;
        if (done_after_dump) begin
          check("done_after_we49_delay", 32'(cyc - last_we_cyc), 1);
          check("done_after_we49_addr", 32'(last_we_addr), 49);
        end else begin
          check("done_after_busy_fall", 32'(cyc - busy_fall_cyc), 1);
        end
      end
      if (o_error) begin
        err_seen++;
        check("error_expected_pending", 32'(exp_err > 0), 1);
        if (exp_err > 0) exp_err--;
        check("error_idle_cycles", 32'(cyc - last_rx_cyc), 32'(RX_TO + 1));
        check("ready_with_error", 32'(o_cmd_ready), 1);
      end
    end
    prev_busy = i_tx_busy;
  end

  task automatic push_word_bytes(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx_q.push_back(w[8*i +: 8]);
  endtask

  // LOAD reference: 'd', then ROM words MSB first up to and including a halt
  // word; the last slot is always sent as the halt word.
  task automatic push_load_expect();
    logic [31:0] w;
    exp_tx_q.push_back(8'h64);
    for (int a = 0; a < 256; a++) begin
      w = (a == 255) ? HALT : rom[a];
      push_word_bytes(w);
      if (w == HALT) break;
    end
  endtask

  function automatic logic [31:0] rand_nonhalt();
    logic [31:0] w = $urandom;
    if (w == HALT) w = 32'h1234_5678;
    return w;
  endfunction

  task automatic issue_cmd(input logic [1:0] c);
    int n = 0;
    while (!o_cmd_ready && n < 1000) begin @(negedge i_clk); n++; end
    check("ready_before_issue", 32'(o_cmd_ready), 1);
    i_cmd = c;
    i_cmd_valid = 1'b1;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int budget, input string name);
    int n = 0;
    while (done_seen == d0 && err_seen == e0 && n < budget) begin @(negedge i_clk); n++; end
    check(name, 32'((done_seen != d0) || (err_seen != e0)), 1);
  endtask

  task automatic wait_cmd_sent(input int t0);
    int n = 0;
    while (tx_seen == t0 && n < 300) begin @(negedge i_clk); n++; end
    while (!i_tx_busy && n < 300) begin @(negedge i_clk); n++; end
    while (i_tx_busy && n < 300) begin @(negedge i_clk); n++; end
    check("cmd_byte_sent", 32'(n < 300), 1);
    repeat (2) @(negedge i_clk);
  endtask

  // Target reply: bytes with random gaps; command noise while the DUT is busy.
  task automatic send_rx();
    int sz = rx_q.size();
    for (int i = 0; i < sz; i++) begin
      i_rx_valid  = 1'b1;
      i_rx_data   = rx_q[i];
      last_rx_cyc = cyc;
      @(negedge i_clk);
      i_rx_valid = 1'b0;
      if (i < sz - 1) begin
        repeat ($urandom_range(1, 5)) begin
          i_cmd_valid = ($urandom_range(0, 3) == 0);
          i_cmd       = 2'($urandom);
          @(negedge i_clk);
        end
        i_cmd_valid = 1'b0;
      end
    end
    rx_q.delete();
  endtask

  // RUN/NEXT: dump of PC, cycle count, registers and memory.
  task automatic run_dump(input logic [1:0] c, input logic [31:0] pc, input bit fixed);
    logic [31:0] w;
    int t0, d0, e0, w0;
    exp_tx_q.push_back(c == 2'd1 ? 8'h63 : 8'h6E);
    for (int i = 0; i < 50; i++) begin
      if (i == 0)      w = pc;
      else if (i == 1) w = fixed ? 32'h2A : $urandom;
      else if (i < 34) w = fixed ? 32'(i - 2) : $urandom;
      else             w = fixed ? 32'h100 + 32'(i - 34) : $urandom;
      exp_dump_q.push_back({6'(i), w});
      for (int b = 3; b >= 0; b--) rx_q.push_back(w[8*b +: 8]);
    end
    exp_done++;
    done_after_dump = 1;
    t0 = tx_seen; d0 = done_seen; e0 = err_seen; w0 = we_seen;
    issue_cmd(c);
    wait_cmd_sent(t0);
    send_rx();
    wait_end(d0, e0, 200, "dump_completed");
    check("dump_queue_drained", 32'(exp_dump_q.size()), 0);
    check("dump_write_count", 32'(we_seen - w0), 50);
    check("dump_no_error", 32'(err_seen - e0), 0);
  endtask

  task automatic run_load(input int budget);
    int d0, e0;
    push_load_expect();
    exp_done++;
    done_after_dump = 0;
    d0 = done_seen; e0 = err_seen;
    issue_cmd(2'd0);
    wait_end(d0, e0, budget, "load_completed");
    check("load_queue_drained", 32'(exp_tx_q.size()), 0);
  endtask

  initial begin
    int t0, d0, e0, w0, n;
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = '0; i_rx_valid = 1'b0; i_rx_data = '0;
    for (int a = 0; a < 256; a++) rom[a] = 32'h0;
    repeat (3) @(negedge i_clk);
    check("reset_cmd_ready", 32'(o_cmd_ready), 0);
    check("reset_tx_start", 32'(o_tx_start), 0);
    check("reset_prog_addr", 32'(o_prog_addr), 0);
    check("reset_dump_we", 32'(o_dump_we), 0);
    check("reset_done_error", 32'({o_done, o_error}), 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("ready_after_release", 32'(o_cmd_ready), 1);

    // Short program terminated by a halt word.
    rom[0] = 32'h2001_0005; rom[1] = HALT;
    run_load(500);

    // No halt word: all 256 slots sent, last forced to halt.
    rom[0] = 32'h0; rom[1] = 32'h0;
    max_addr = 0; t0 = tx_seen;
    run_load(20000);
    check("load_zero_byte_count", 32'(tx_seen - t0), 1025);
    check("load_zero_max_addr", 32'(max_addr), 255);

    // Stray receive strobe while idle must not disturb the next dump.
    i_rx_valid = 1'b1; i_rx_data = 8'hA5; @(negedge i_clk); i_rx_valid = 1'b0;
    busy_len = $urandom_range(2, 12);
    run_dump(2'd1, 32'h0000_0010, 1'b1);

    // STEP then NEXT.
    exp_tx_q.push_back(8'h73);
    exp_done++; done_after_dump = 0;
    d0 = done_seen; e0 = err_seen;
    issue_cmd(2'd2);
    wait_end(d0, e0, 200, "step_completed");
    run_dump(2'd3, $urandom, 1'b0);

    // Reply stalls after 7 bytes: timeout, one dump write, no done.
    exp_tx_q.push_back(8'h63);
    exp_dump_q.push_back({6'd0, 32'hDEAD_BEEF});
    rx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h11, 8'h22, 8'h33};
    exp_err++;
    t0 = tx_seen; d0 = done_seen; e0 = err_seen; w0 = we_seen;
    issue_cmd(2'd1);
    wait_cmd_sent(t0);
    send_rx();
    wait_end(d0, e0, 300, "timeout_reported");
    check("timeout_write_count", 32'(we_seen - w0), 1);
    check("timeout_no_done", 32'(done_seen - d0), 0);
    @(negedge i_clk);
    check("timeout_ready_after", 32'(o_cmd_ready), 1);

    // Reset while the first byte of LOAD word 1 is in flight.
    busy_len = 10;
    for (int a = 0; a < 3; a++) rom[a] = rand_nonhalt();
    rom[3] = HALT;
    push_load_expect();
    t0 = tx_seen; d0 = done_seen; e0 = err_seen; n = 0;
    issue_cmd(2'd0);
    while (tx_seen < t0 + 6 && n < 500) begin @(negedge i_clk); n++; end
    check("reset_point_reached", 32'(tx_seen - t0), 6);
    i_reset = 1'b1;
    exp_tx_q.delete();
    @(negedge i_clk);
    check("midreset_cmd_ready", 32'(o_cmd_ready), 0);
    check("midreset_tx_start", 32'(o_tx_start), 0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check("midreset_idle_next", 32'(o_cmd_ready), 1);
    repeat (30) @(negedge i_clk);
    check("midreset_no_tx", 32'(tx_seen - t0), 6);
    check("midreset_no_done_error", 32'((done_seen - d0) + (err_seen - e0)), 0);
    run_dump(2'd1, $urandom, 1'b0);

    // Random short programs with random UART busy time.
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(1, 8);
      busy_len = $urandom_range(1, 12);
      for (int a = 0; a < n - 1; a++) rom[a] = rand_nonhalt();
      rom[n-1] = HALT;
      run_load(2000);
    end

    repeat (5) @(negedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
